addr_scanner: RTL and testbench
===============================

Name: addr_scanner

Overview:
Downstream consumer of the free-running divided-clock bus. Selects one tap of divided_clocks and turns its rising edges into single-cycle tick enables in the 50 MHz domain. Uses those ticks, or a manual step input, to drive a wrapping read address that sweeps a memory block at human-visible rates. Provides run/pause control, synchronous address load and a wrap indicator. No logic runs on a derived clock.

Parameters:
ADDR_W, 5, width of rd_addr
MAX_ADDR, 31, last address before wrap to 0; must be < 2**ADDR_W

Ports:
clock  in  1  50 MHz system clock; all flops on posedge
reset  in  1  asynchronous, active-high reset
divided_clocks  in  32  counter bus from the divider, same clock domain
tap_sel  in  5  index of divided_clocks bit used as tick source
run  in  1  level: 1 = auto-advance on ticks, 0 = pause
step  in  1  level, already synchronized; each rising edge advances one address while paused
load  in  1  synchronous load strobe
load_addr  in  ADDR_W  value loaded when load=1
tick  out  1  one-cycle pulse per rising edge of selected tap
rd_addr  out  ADDR_W  current read address
wrap  out  1  one-cycle pulse when rd_addr wraps MAX_ADDR -> 0
running  out  1  1 when FSM is in RUN

Behaviour:
- Reset (async, immediate): rd_addr=0, wrap=0, running=0, FSM=PAUSE, tap_q=0, tap_prev=0, step_q=0, suppress counter=2.
- Tap pipeline: tap_q <= divided_clocks[tap_sel]; tap_prev <= tap_q. tick = tap_q & ~tap_prev & (suppress==0). tick is combinational from flops and is 0 during reset.
- Suppression: suppress decrements to 0, one per cycle. tap_sel_q registers tap_sel. Any cycle with tap_sel != tap_sel_q reloads suppress=2. There are no spurious ticks after reset or a tap change.
- Tap 0: tick every 2 cycles. Tap n: one tick every 2**(n+1) cycles.
- step_pulse = step & ~step_q; step_q <= step. Holding step high gives exactly one pulse.
- FSM, 2 states:
  - PAUSE -> RUN when run=1.
  - RUN -> PAUSE when run=0.
  - Transitions take effect at the next edge. running = (state==RUN).
- Address update, evaluated with the current registered state, priority order:
  1. load=1: rd_addr <= min(load_addr, MAX_ADDR), wrap <= 0.
  2. Advance condition: (state==RUN & tick) | (state==PAUSE & step_pulse).
  3. If advancing and rd_addr==MAX_ADDR: rd_addr <= 0, wrap <= 1.
  4. If advancing otherwise: rd_addr <= rd_addr+1, wrap <= 0.
  5. No advance: hold, wrap <= 0.
- Latency: tick or step_pulse high in cycle k means rd_addr has the new value from edge k+1. wrap is high for exactly that one cycle.
- Ignored inputs: tick is ignored in PAUSE; step_pulse is ignored in RUN.
- Run dropping: if tick coincides with the cycle run drops, the increment still occurs because state is still RUN.
- Load: load + tick or load + step in the same cycle -> load wins, no increment, no wrap.
- Reset mid-operation: all state cleared at once; no tick for the 2 cycles after release.

Test Plan:
- Reset with divided_clocks driven by a live divider -> rd_addr=0, wrap=0, running=0, tick=0 for the first 2 cycles after release.
- tap_sel=0, run=1 -> tick every 2nd cycle; rd_addr counts 0,1,2,... one per tick, each update one cycle after its tick.
- MAX_ADDR=31, load_addr=30 then run -> rd_addr 30,31,0; wrap high exactly one cycle, coincident with rd_addr=0.
- run=0, step held high 5 cycles, then low, then high again -> rd_addr advances exactly 2; ticks on tap 0 cause no change.
- load=1, load_addr=7 in the same cycle as a tick in RUN -> rd_addr=7, no increment, wrap=0.
- load_addr=31 with MAX_ADDR=20 -> rd_addr=20.
- tap_sel switched 3 -> 0 while running -> no tick for 2 cycles after the change, then ticks every 2 cycles.
- Assert reset mid-run at rd_addr=12 -> rd_addr=0 and running=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/addr_scanner.sv
// addr_scanner: turns rising edges of one divider tap into single-cycle ticks and
// sweeps a wrapping read address with run/pause, manual step and synchronous load.
module addr_scanner #(
    parameter int ADDR_W   = 5,
    parameter int MAX_ADDR = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       divided_clocks,
    input  logic [4:0]        tap_sel,
    input  logic              run,
    input  logic              step,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              tick,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wrap,
    output logic              running
);

    localparam logic [1:0]        ST_PAUSE = 2'b01;
    localparam logic [1:0]        ST_RUN   = 2'b10;
    localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic              tap_q, tap_d;
    logic              tap_prev_q;
    logic [4:0]        tap_sel_q;
    logic [1:0]        suppress_q, suppress_d;
    logic              step_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              tick_s;
    logic              step_pulse_s;
    logic              advance_s;
    logic [ADDR_W-1:0] load_clamped_s;

    // Edge detection on the selected tap and the step level, plus tick suppression window.
    always_comb begin
        tap_d        = divided_clocks[tap_sel];
        tick_s       = tap_q & ~tap_prev_q & (suppress_q == 2'd0);
        step_pulse_s = step & ~step_q;
        // A tap change mixes samples of two different bits in the pipeline; mask them out.
        if (tap_sel != tap_sel_q) begin
            suppress_d = 2'd2;
        end else if (suppress_q != 2'd0) begin
            suppress_d = suppress_q - 2'd1;
        end else begin
            suppress_d = 2'd0;
        end
    end

    // Run/pause state machine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PAUSE: begin
                if (run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_PAUSE;
        endcase
    end

    // Address update: load beats advance; advance source depends on the current state.
    always_comb begin
        addr_d         = addr_q;
        wrap_d         = 1'b0;
        load_clamped_s = (load_addr >= MAX_A) ? MAX_A : load_addr;
        advance_s      = ((state_q == ST_RUN) & tick_s) | ((state_q == ST_PAUSE) & step_pulse_s);
        if (load) begin
            addr_d = load_clamped_s;
            wrap_d = 1'b0;
        end else if (advance_s) begin
            if (addr_q == MAX_A) begin
                addr_d = {ADDR_W{1'b0}};
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + ONE_A;
                wrap_d = 1'b0;
            end
        end else begin
            addr_d = addr_q;
            wrap_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_PAUSE;
            tap_q      <= 1'b0;
            tap_prev_q <= 1'b0;
            tap_sel_q  <= 5'd0;
            suppress_q <= 2'd2;
            step_q     <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            tap_prev_q <= tap_q;
            tap_sel_q  <= tap_sel;
            suppress_q <= suppress_d;
            step_q     <= step;
            addr_q     <= addr_d;
            wrap_q     <= wrap_d;
        end
    end

    assign tick    = tick_s;
    assign rd_addr = addr_q;
    assign wrap    = wrap_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_addr_scanner.sv
// Scoreboard bench for addr_scanner: a behavioural model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_addr_scanner;

    localparam int AW   = 5;
    localparam int MAXA = 31;
    localparam int MAXB = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   div_cnt = 32'd0;
    logic [4:0]    tap_sel = 5'd0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          load = 1'b0;
    logic [AW-1:0] load_addr = 5'd0;

    logic          tick, wrap, running;
    logic [AW-1:0] rd_addr;
    logic          tick_b, wrap_b, running_b;
    logic [AW-1:0] rd_addr_b;

    addr_scanner #(.ADDR_W(AW), .MAX_ADDR(MAXA)) u_dut (
        .clock(clock), .reset(reset), .divided_clocks(div_cnt), .tap_sel(tap_sel),
        .run(run), .step(step), .load(load), .load_addr(load_addr),
        .tick(tick), .rd_addr(rd_addr), .wrap(wrap), .running(running)
    );

    addr_scanner #(.ADDR_W(AW), .MAX_ADDR(MAXB)) u_dut20 (
        .clock(clock), .reset(reset), .divided_clocks(div_cnt), .tap_sel(tap_sel),
        .run(run), .step(step), .load(load), .load_addr(load_addr),
        .tick(tick_b), .rd_addr(rd_addr_b), .wrap(wrap_b), .running(running_b)
    );

    always #5 clock = ~clock;

    // Live divider: free-running counter in the same clock domain.
    always @(posedge clock) div_cnt <= div_cnt + 32'd1;

    typedef struct {
        bit tick;
        int addr;
        bit wrap;
        bit running;
        bit chk_b;
        int addr_b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   in_reset = 1'b1;

    // Reference model state
    int m_addr, m_addr_b, m_since, m_sel_prev;
    bit m_run, m_wrap, m_step_prev, m_s0, m_s1, m_chk_b;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit model_tick();
        return m_s1 && !m_s0 && (m_since >= 2);
    endfunction

    task automatic model_reset();
        m_addr = 0; m_addr_b = 0; m_since = 0; m_sel_prev = 0;
        m_run = 0; m_wrap = 0; m_step_prev = 0; m_s0 = 0; m_s1 = 0; m_chk_b = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently on the bus.
    task automatic model_step();
        bit t, sp, adv;
        int la;
        t   = model_tick();
        sp  = step && !m_step_prev;
        adv = m_run ? t : sp;
        la  = int'(load_addr);
        if (load) begin
            m_addr   = (la > MAXA) ? MAXA : la;
            m_addr_b = (la > MAXB) ? MAXB : la;
            m_wrap   = 0;
            m_chk_b  = 1;
        end else begin
            m_chk_b = 0;
            if (adv && m_addr == MAXA) begin
                m_addr = 0;
                m_wrap = 1;
            end else if (adv) begin
                m_addr = m_addr + 1;
                m_wrap = 0;
            end else begin
                m_wrap = 0;
            end
        end
        m_run       = run;
        m_step_prev = step;
        m_s0        = m_s1;
        m_s1        = div_cnt[tap_sel];
        if (int'(tap_sel) != m_sel_prev) m_since = 0;
        else m_since = m_since + 1;
        m_sel_prev = int'(tap_sel);
    endtask

    task automatic next_cycle();
        exp_t e;
        @(posedge clock);
        #1;
        e.tick = model_tick(); e.addr = m_addr; e.wrap = m_wrap; e.running = m_run;
        e.chk_b = m_chk_b; e.addr_b = m_addr_b;
        q.push_back(e);
    endtask

    task automatic drive(input int s, input bit r, input bit st, input bit l, input int la);
        tap_sel = 5'(s); run = r; step = st; load = l; load_addr = 5'(la);
        model_step();
    endtask

    task automatic cyc(input int s, input bit r, input bit st, input bit l, input int la);
        next_cycle();
        drive(s, r, st, l, la);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_running"}, int'(running), 0);
        chk({tag, "_wrap"}, int'(wrap), 0);
        chk({tag, "_tick"}, int'(tick), 0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        model_step();
        in_reset = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!in_reset && q.size() > 0) begin
            e = q.pop_front();
            chk("tick", int'(tick), int'(e.tick));
            chk("rd_addr", int'(rd_addr), e.addr);
            chk("wrap", int'(wrap), int'(e.wrap));
            chk("running", int'(running), int'(e.running));
            if (e.chk_b) chk("clamp_max20", int'(rd_addr_b), e.addr_b);
        end
    end

    initial begin
        bit found;
        int s, r, st;
        model_reset();
        #2;
        check_reset_outputs("por");
        repeat (3) @(posedge clock);
        release_reset();

        // Tap 0 auto-run from address 0
        repeat (24) cyc(0, 1, 0, 0, 0);

        // Load 30 and run through the wrap
        cyc(0, 0, 0, 1, 30);
        repeat (12) cyc(0, 1, 0, 0, 0);

        // Pause: step held high, low, high again -> two advances only
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);

        // Load collides with a tick in RUN
        repeat (3) cyc(0, 1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            next_cycle();
            if (model_tick()) begin
                drive(0, 1, 0, 1, 7);
                found = 1;
            end else begin
                drive(0, 1, 0, 0, 0);
            end
        end
        chk("tick_found_for_load", int'(found), 1);
        next_cycle();
        drive(0, 1, 0, 0, 0);
        chk("load_over_tick", int'(rd_addr), 7);
        chk("load_over_tick_wrap", int'(wrap), 0);

        // Clamp against the MAX_ADDR=20 instance
        cyc(0, 0, 0, 1, 31);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        chk("clamp20_direct", int'(rd_addr_b), MAXB);

        // Tap switch 3 -> 0 while running
        repeat (40) cyc(3, 1, 0, 0, 0);
        repeat (20) cyc(0, 1, 0, 0, 0);

        // Asynchronous reset mid-run at address 12
        cyc(0, 1, 0, 1, 12);
        next_cycle();
        drive(0, 1, 0, 0, 0);
        chk("pre_reset_addr", int'(rd_addr), 12);
        #2;
        in_reset = 1'b1;
        q.delete();
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("held");
        release_reset();

        // Randomized operation
        s = 0; r = 1; st = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) s = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) r = 1 - r;
            if ($urandom_range(0, 3) == 0) st = 1 - st;
            if ($urandom_range(0, 39) == 0) cyc(s, r[0], st[0], 1, $urandom_range(0, 31));
            else cyc(s, r[0], st[0], 0, 0);
        end

        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
